// File: rtl/rtc_digit_writer_pkg.sv
// Shared definitions for the RTC digit writer: FSM encoding, field indices,
// RTC register address map and the BCD validity check.
package rtc_digit_writer_pkg;

  localparam int N_FIELDS = 9;
  localparam int DW       = 8;

  localparam logic [3:0] IDX_HO     = 4'd0;
  localparam logic [3:0] IDX_MIN    = 4'd1;
  localparam logic [3:0] IDX_SEG    = 4'd2;
  localparam logic [3:0] IDX_MES    = 4'd3;
  localparam logic [3:0] IDX_DIA    = 4'd4;
  localparam logic [3:0] IDX_AN     = 4'd5;
  localparam logic [3:0] IDX_HO_TI  = 4'd6;
  localparam logic [3:0] IDX_MIN_TI = 4'd7;
  localparam logic [3:0] IDX_SEG_TI = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_CHECK = 3'd2,
    S_ADDR  = 3'd3,
    S_DATA  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  function automatic logic [DW-1:0] field_addr(input logic [3:0] idx);
    logic [DW-1:0] a;
    case (idx)
      IDX_HO:     a = 8'h23;
      IDX_MIN:    a = 8'h22;
      IDX_SEG:    a = 8'h21;
      IDX_MES:    a = 8'h25;
      IDX_DIA:    a = 8'h24;
      IDX_AN:     a = 8'h26;
      IDX_HO_TI:  a = 8'h43;
      IDX_MIN_TI: a = 8'h42;
      IDX_SEG_TI: a = 8'h41;
      default:    a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic bcd_ok(input logic [DW-1:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_digit_writer.sv
// Snapshots nine BCD time/date/timer fields on start and streams each enabled,
// valid field to the RTC bus engine as an address byte then a data byte (valid/ready).
module rtc_digit_writer
  import rtc_digit_writer_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [8:0]    field_en_i,
  input  logic [7:0]    fld_ho_i,
  input  logic [7:0]    fld_min_i,
  input  logic [7:0]    fld_seg_i,
  input  logic [7:0]    fld_mes_i,
  input  logic [7:0]    fld_dia_i,
  input  logic [7:0]    fld_an_i,
  input  logic [7:0]    fld_ho_ti_i,
  input  logic [7:0]    fld_min_ti_i,
  input  logic [7:0]    fld_seg_ti_i,
  output logic          bus_valid_o,
  input  logic          bus_ready_i,
  output logic          bus_ad_o,
  output logic [7:0]    bus_byte_o,
  output logic [3:0]    cuenta_escritura_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          bad_bcd_o
);

  logic [N_FIELDS-1:0][DW-1:0] fld_in;
  logic [N_FIELDS-1:0][DW-1:0] snap_q, snap_d;
  logic [N_FIELDS-1:0]         en_q, en_d;
  logic [3:0]                  idx_q, idx_d;
  state_e                      state_q, state_d;
  logic                        bad_q, bad_d;
  logic                        bus_valid_q, bus_valid_d;
  logic                        bus_ad_q, bus_ad_d;
  logic [DW-1:0]               bus_byte_q, bus_byte_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  assign fld_in = {fld_seg_ti_i, fld_min_ti_i, fld_ho_ti_i, fld_an_i, fld_dia_i,
                   fld_mes_i, fld_seg_i, fld_min_i, fld_ho_i};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    en_d    = en_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LATCH;
          bad_d   = 1'b0;
          idx_d   = 4'd0;
        end
      end
      S_LATCH: begin
        snap_d  = fld_in;
        en_d    = field_en_i;
        idx_d   = 4'd0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!en_q[idx_q]) begin
          state_d = S_NEXT;
        end else if (!bcd_ok(snap_q[idx_q])) begin
          bad_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          state_d = S_ADDR;
        end
      end
      // bus_valid is always high in ADDR/DATA, so ready alone completes the handshake.
      S_ADDR: if (bus_ready_i) state_d = S_DATA;
      S_DATA: if (bus_ready_i) state_d = S_NEXT;
      S_NEXT: begin
        if (idx_q == IDX_SEG_TI) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_CHECK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    bus_valid_d = (state_d == S_ADDR) || (state_d == S_DATA);
    bus_ad_d    = (state_d == S_ADDR);
    bus_byte_d  = 8'h00;
    if (state_d == S_ADDR) bus_byte_d = field_addr(idx_d);
    if (state_d == S_DATA) bus_byte_d = snap_d[idx_d];
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      snap_q      <= '0;
      en_q        <= '0;
      bad_q       <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_ad_q    <= 1'b0;
      bus_byte_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      en_q        <= en_d;
      bad_q       <= bad_d;
      bus_valid_q <= bus_valid_d;
      bus_ad_q    <= bus_ad_d;
      bus_byte_q  <= bus_byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus_valid_o        = bus_valid_q;
  assign bus_ad_o           = bus_ad_q;
  assign bus_byte_o         = bus_byte_q;
  assign cuenta_escritura_o = idx_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign bad_bcd_o          = bad_q;

endmodule
